wb_stage_reg: RTL and testbench
===============================

// Module: wb_stage_reg
// PURPOSE
//   Registered writeback stage: MEM/WB pipeline register plus a 4-way result select,
//   load-data alignment with sign/zero extension, stall/flush control and a count of
//   retired instructions. Sits between the MEM stage and the register file write port.
//   Register-file write signals are valid one cycle after the MEM-stage inputs.
// PARAMETERS
//   NB_REG   32  datapath width; must be >= 32
//   NB_ADDR  5   register-file address width
//   NB_CNT   32  retired-instruction counter width
// PORTS
//   i_clk            in   1        clock, rising edge
//   i_rst            in   1        synchronous reset, active-high
//   i_stall          in   1        hold the stage contents
//   i_flush          in   1        insert a bubble
//   i_valid          in   1        MEM-stage instruction is valid
//   i_alu_result     in   NB_REG   ALU result
//   i_data_from_mem  in   NB_REG   raw data-memory read word
//   i_pcplus8        in   NB_REG   return address for jal/jalr
//   i_imm_data       in   NB_REG   pre-shifted immediate (lui)
//   i_wb_sel         in   2        00=alu, 01=mem, 10=pc+8, 11=imm
//   i_load_size      in   2        00=byte, 01=half, 1x=word
//   i_load_unsigned  in   1        1=zero-extend, 0=sign-extend
//   i_byte_offset    in   2        address bits [1:0] of the load
//   i_reg_write      in   1        instruction writes the register file
//   i_rd_addr        in   NB_ADDR  destination register
//   o_valid          out  1        stage holds a valid instruction
//   o_reg_write      out  1        register-file write enable
//   o_rd_addr        out  NB_ADDR  register-file write address
//   o_data_to_reg    out  NB_REG   register-file write data
//   o_retired_count  out  NB_CNT   count of retired instructions
// BEHAVIOUR
//   - Reset: one clock, synchronous, active-high. All outputs are 0, including the counter.
//   - Per-edge priority: i_rst > i_flush > i_stall > load.
//   - Load: all outputs capture the next-state values computed combinationally from the
//     current inputs. Latency is 1 cycle.
//   - Flush: o_valid=0, o_reg_write=0, o_rd_addr=0, o_data_to_reg=0; counter unchanged.
//     Flush wins when asserted together with stall.
//   - Stall without flush: every output holds its value, including the counter.
//   - Write-enable rule: next o_reg_write = i_valid & i_reg_write & (i_rd_addr != 0).
//     There is never a write to $0.
//   - Invalid capture: if i_valid=0 on a load edge, o_valid=0 and o_reg_write=0. Data and
//     address are still captured.
//   - Counter: increments by 1 on a load edge with i_valid=1, whether or not the
//     instruction writes a register. Wraps from 2^NB_CNT-1 to 0.
//   - Result select: i_wb_sel picks the next o_data_to_reg. The mem path uses the
//     extended load value.
//   - Load extension (lanes little-endian; byte k = data[8k+7:8k]):
//       byte: lane = i_byte_offset; extend 8 bits to NB_REG.
//       half: lane = i_byte_offset[1] (bit 0 ignored); extend 16 bits to NB_REG.
//       word: low 32 bits used; if NB_REG>32, extended per i_load_unsigned.
//     Sign-extension replicates the top bit of the lane. Zero-extension fills with 0.
//   - Misaligned accesses are not detected here; they are resolved by the lane rules above.
// CONFIGURATION
//   WB_LOAD_EXT_EN defined:   load extension as specified above.
//   WB_LOAD_EXT_EN undefined: the mem path forwards i_data_from_mem unmodified;
//     i_load_size, i_load_unsigned and i_byte_offset are ignored. All other behaviour
//     is identical.
// TESTING
//   1. Reset: i_rst=1 for 2 cycles with random inputs -> all outputs 0 and counter 0
//      after the first edge.
//   2. Select: alu=0x11, mem=0x22, pc8=0x33, imm=0x44; wb_sel 00..11 with rd=5, valid
//      -> o_data_to_reg 0x11,0x22,0x33,0x44 one cycle later; o_reg_write=1; counter +4.
//   3. Extension (WB_LOAD_EXT_EN): mem=0x8081F0F7 ->
//      byte off0 signed = 0xFFFFFFF7; byte off3 unsigned = 0x00000080;
//      half off2 signed = 0xFFFF8081; half off1 unsigned = 0x0000F0F7; word = 0x8081F0F7.
//      Without the macro, every case returns 0x8081F0F7.
//   4. $0 guard: i_reg_write=1, i_rd_addr=0, valid -> o_reg_write=0, o_valid=1, counter +1.
//   5. Stall/flush: load rd=7 data=0xAA; stall 3 cycles with new inputs -> outputs and
//      counter held. Stall+flush together -> bubble: o_valid=0, o_reg_write=0, data 0,
//      counter unchanged.
//   6. Wrap: NB_CNT=4; retire 17 valid instructions -> counter reads 1; reset mid-run
//      -> counter 0 on the next edge.

Source files
------------

// File: rtl/wb_stage_reg_if.sv
// MEM-to-writeback bundle: MEM-stage inputs and register-file write outputs of wb_stage_reg.
// master drives the MEM-side fields, slave is the stage register itself.
interface wb_stage_reg_if #(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 32
);
    logic                i_stall;
    logic                i_flush;
    logic                i_valid;
    logic [NB_REG-1:0]   i_alu_result;
    logic [NB_REG-1:0]   i_data_from_mem;
    logic [NB_REG-1:0]   i_pcplus8;
    logic [NB_REG-1:0]   i_imm_data;
    logic [1:0]          i_wb_sel;
    logic [1:0]          i_load_size;
    logic                i_load_unsigned;
    logic [1:0]          i_byte_offset;
    logic                i_reg_write;
    logic [NB_ADDR-1:0]  i_rd_addr;
    logic                o_valid;
    logic                o_reg_write;
    logic [NB_ADDR-1:0]  o_rd_addr;
    logic [NB_REG-1:0]   o_data_to_reg;
    logic [NB_CNT-1:0]   o_retired_count;

    modport master (
        output i_stall, i_flush, i_valid, i_alu_result, i_data_from_mem, i_pcplus8,
               i_imm_data, i_wb_sel, i_load_size, i_load_unsigned, i_byte_offset,
               i_reg_write, i_rd_addr,
        input  o_valid, o_reg_write, o_rd_addr, o_data_to_reg, o_retired_count
    );

    modport slave (
        input  i_stall, i_flush, i_valid, i_alu_result, i_data_from_mem, i_pcplus8,
               i_imm_data, i_wb_sel, i_load_size, i_load_unsigned, i_byte_offset,
               i_reg_write, i_rd_addr,
        output o_valid, o_reg_write, o_rd_addr, o_data_to_reg, o_retired_count
    );
endinterface

// File: rtl/wb_stage_reg.sv
// MEM/WB register with result select and retire counter; WB_LOAD_EXT_EN adds load lane alignment/extension.
// Latency 1 cycle; i_stall holds every output, i_flush inserts a bubble (no ready backpressure).
module wb_stage_reg #(
    parameter int NB_REG  = 32,
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    wb_stage_reg_if.slave  wb
);
    logic [NB_REG-1:0]  load_val;
    logic [NB_REG-1:0]  data_next;
    logic               we_next;

    logic               valid_q;
    logic               we_q;
    logic [NB_ADDR-1:0] rd_q;
    logic [NB_REG-1:0]  data_q;
    logic [NB_CNT-1:0]  cnt_q;

`ifdef WB_LOAD_EXT_EN
    logic [31:0]       word;
    logic [7:0]        lane8;
    logic [15:0]       lane16;
    logic [NB_REG-1:0] fill;

    // Fill pattern is shifted above the lane so one path covers byte, half and word.
    always_comb begin
        word   = wb.i_data_from_mem[31:0];
        lane8  = word[7:0];
        case (wb.i_byte_offset)
            2'd1:    lane8 = word[15:8];
            2'd2:    lane8 = word[23:16];
            2'd3:    lane8 = word[31:24];
            default: lane8 = word[7:0];
        endcase
        lane16 = wb.i_byte_offset[1] ? word[31:16] : word[15:0];
        case (wb.i_load_size)
            2'b00: begin
                fill     = {NB_REG{~wb.i_load_unsigned & lane8[7]}};
                load_val = (fill << 8) | NB_REG'(lane8);
            end
            2'b01: begin
                fill     = {NB_REG{~wb.i_load_unsigned & lane16[15]}};
                load_val = (fill << 16) | NB_REG'(lane16);
            end
            default: begin
                fill     = {NB_REG{~wb.i_load_unsigned & word[31]}};
                load_val = (fill << 32) | NB_REG'(word);
            end
        endcase
    end
`else
    logic unused_load_ctl;
    assign unused_load_ctl = ^{wb.i_load_size, wb.i_load_unsigned, wb.i_byte_offset};
    assign load_val        = wb.i_data_from_mem;
`endif

    always_comb begin
        data_next = wb.i_alu_result;
        case (wb.i_wb_sel)
            2'b01:   data_next = load_val;
            2'b10:   data_next = wb.i_pcplus8;
            2'b11:   data_next = wb.i_imm_data;
            default: data_next = wb.i_alu_result;
        endcase
        we_next = wb.i_valid & wb.i_reg_write & (wb.i_rd_addr != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (wb.i_flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else if (!wb.i_stall) begin
            valid_q <= wb.i_valid;
            we_q    <= we_next;
            rd_q    <= wb.i_rd_addr;
            data_q  <= data_next;
            if (wb.i_valid)
                cnt_q <= cnt_q + NB_CNT'(1);
        end
    end

    assign wb.o_valid         = valid_q;
    assign wb.o_reg_write     = we_q;
    assign wb.o_rd_addr       = rd_q;
    assign wb.o_data_to_reg   = data_q;
    assign wb.o_retired_count = cnt_q;
endmodule

// File: tb/tb_wb_stage_reg.sv
// Scoreboard bench for wb_stage_reg: stimulus pushes expected outputs, a monitor pops and compares.
module tb_wb_stage_reg;
    localparam int NB_REG  = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_CNT  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_reg_if #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) bus ();

    wb_stage_reg #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .wb    (bus)
    );

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [3:0]  c;
    } st_t;

    st_t m;
    st_t q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic logic [31:0] load_model(input logic [31:0] d, input logic [1:0] sz,
                                               input logic uns, input logic [1:0] off);
`ifdef WB_LOAD_EXT_EN
        int unsigned v;
        if (sz == 2'b00) begin
            v = (d >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (d >> (off[1] ? 16 : 0)) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
`else
        return d;
`endif
    endfunction

    // Advance one clock; the expected post-edge state is queued before the edge.
    task automatic tick();
        st_t n;
        n = m;
        if (rst) begin
            n = '0;
        end else if (bus.i_flush) begin
            n.v = 0; n.we = 0; n.rd = 0; n.d = 0;
        end else if (!bus.i_stall) begin
            n.v  = bus.i_valid;
            n.we = bus.i_valid && bus.i_reg_write && (bus.i_rd_addr != 0);
            n.rd = bus.i_rd_addr;
            case (bus.i_wb_sel)
                2'd0: n.d = bus.i_alu_result;
                2'd1: n.d = load_model(bus.i_data_from_mem, bus.i_load_size,
                                       bus.i_load_unsigned, bus.i_byte_offset);
                2'd2: n.d = bus.i_pcplus8;
                default: n.d = bus.i_imm_data;
            endcase
            if (bus.i_valid) n.c = 4'((int'(m.c) + 1) % 16);
        end
        m = n;
        q.push_back(n);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rnd_data();
        bus.i_alu_result    = $urandom;
        bus.i_data_from_mem = $urandom;
        bus.i_pcplus8       = $urandom;
        bus.i_imm_data      = $urandom;
        bus.i_wb_sel        = 2'($urandom_range(0, 3));
        bus.i_load_size     = 2'($urandom_range(0, 3));
        bus.i_load_unsigned = 1'($urandom_range(0, 1));
        bus.i_byte_offset   = 2'($urandom_range(0, 3));
        bus.i_reg_write     = 1'($urandom_range(0, 1));
        bus.i_rd_addr       = 5'($urandom_range(0, 31));
        bus.i_valid         = 1'($urandom_range(0, 1));
    endtask

    task automatic check_cnt(input string name, input logic [3:0] want);
        tests++;
        if (bus.o_retired_count !== want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, bus.o_retired_count, want);
        end
    endtask

    always @(posedge clk) begin
        st_t exp_s;
        st_t got;
        #1;
        if (q.size() > 0) begin
            exp_s = q.pop_front();
            got   = {bus.o_valid, bus.o_reg_write, bus.o_rd_addr, bus.o_data_to_reg,
                     bus.o_retired_count};
            tests++;
            if (got !== exp_s) begin
                fails++;
                $display("FAIL stage_out got v=%0b we=%0b rd=%0d d=%h c=%0d want v=%0b we=%0b rd=%0d d=%h c=%0d",
                         got.v, got.we, got.rd, got.d, got.c,
                         exp_s.v, exp_s.we, exp_s.rd, exp_s.d, exp_s.c);
            end
        end
    end

    typedef struct packed {
        logic [1:0] sz;
        logic       uns;
        logic [1:0] off;
    } ext_t;

    initial begin
        ext_t ext_tab[5];
        ext_tab[0] = '{2'd0, 1'b0, 2'd0};
        ext_tab[1] = '{2'd0, 1'b1, 2'd3};
        ext_tab[2] = '{2'd1, 1'b0, 2'd2};
        ext_tab[3] = '{2'd1, 1'b1, 2'd1};
        ext_tab[4] = '{2'd2, 1'b0, 2'd0};

        m = '0;
        rst = 1'b1;
        bus.i_stall = 0;
        bus.i_flush = 0;
        rnd_data();
        @(negedge clk);

        // Reset with random inputs
        repeat (2) begin
            rnd_data();
            bus.i_stall = 1'($urandom_range(0, 1));
            bus.i_flush = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 0; bus.i_stall = 0; bus.i_flush = 0;

        // Result select
        bus.i_alu_result = 32'h11; bus.i_data_from_mem = 32'h22;
        bus.i_pcplus8 = 32'h33; bus.i_imm_data = 32'h44;
        bus.i_load_size = 2'b10; bus.i_load_unsigned = 0; bus.i_byte_offset = 0;
        bus.i_valid = 1; bus.i_reg_write = 1; bus.i_rd_addr = 5;
        for (int s = 0; s < 4; s++) begin
            bus.i_wb_sel = 2'(s);
            tick();
        end
        check_cnt("select_count", 4'd4);

        // Load extension
        bus.i_data_from_mem = 32'h8081_F0F7;
        bus.i_wb_sel = 2'b01;
        for (int k = 0; k < 5; k++) begin
            bus.i_load_size = ext_tab[k].sz;
            bus.i_load_unsigned = ext_tab[k].uns;
            bus.i_byte_offset = ext_tab[k].off;
            tick();
        end

        // Write to $0 suppressed but still retires
        bus.i_rd_addr = 0; bus.i_reg_write = 1; bus.i_valid = 1;
        tick();

        // Stall holds, stall+flush bubbles
        bus.i_wb_sel = 0; bus.i_alu_result = 32'hAA; bus.i_rd_addr = 7;
        tick();
        bus.i_stall = 1;
        repeat (3) begin
            rnd_data();
            tick();
        end
        bus.i_flush = 1;
        tick();
        bus.i_stall = 0; bus.i_flush = 0;

        // Counter wrap and mid-run reset
        rst = 1; tick(); rst = 0;
        repeat (17) begin
            rnd_data();
            bus.i_valid = 1;
            tick();
        end
        check_cnt("wrap_count", 4'd1);
        rst = 1; rnd_data(); tick(); rst = 0;
        check_cnt("reset_count", 4'd0);

        // Random mix
        repeat (400) begin
            rnd_data();
            bus.i_stall = ($urandom_range(0, 4) == 0);
            bus.i_flush = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 0; bus.i_stall = 0; bus.i_flush = 0;

        repeat (2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d left want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
